// File: rtl/mii_rx_framer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mii_rx_framer_if : MII receive pins plus framed byte stream       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface mii_rx_framer_if #(
  parameter int LEN_W = 16
);
  logic             eth_rx_dv;
  logic [3:0]       eth_rxd;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_sof;
  logic             out_eof;
  logic             out_err;
  logic [LEN_W-1:0] frame_len;
  logic [LEN_W-1:0] good_cnt;
  logic [LEN_W-1:0] err_cnt;

  // master: the framer (consumes MII, produces the byte stream)
  modport master (
    input  eth_rx_dv, eth_rxd,
    output out_data, out_valid, out_sof, out_eof, out_err,
    output frame_len, good_cnt, err_cnt
  );

  modport slave (
    output eth_rx_dv, eth_rxd,
    input  out_data, out_valid, out_sof, out_eof, out_err,
    input  frame_len, good_cnt, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mii_rx_framer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mii_rx_framer : MII rx preamble/SFD strip, nibble-to-byte framing |
// |   with error flags and frame counters; MII_RX_FCS_CHECK_EN adds   |
// |   a CRC-32 residue check.                                         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mii_rx_framer #(
  parameter int PRE_MIN_NIBBLES = 1,
  parameter int MIN_BYTES       = 64,
  parameter int MAX_BYTES       = 1518,
  parameter int LEN_W           = 16
) (
  input  wire logic       eth_rx_clk,
  input  wire logic       rst,
  mii_rx_framer_if.master rx_bus
);

  localparam logic [1:0]       c_ST_IDLE = 2'd0;
  localparam logic [1:0]       c_ST_PRE  = 2'd1;
  localparam logic [1:0]       c_ST_DATA = 2'd2;
  localparam logic [1:0]       c_ST_DROP = 2'd3;
  localparam logic [3:0]       c_NIB_PRE = 4'h5;
  localparam logic [3:0]       c_NIB_SFD = 4'hD;
  localparam logic [3:0]       c_PRE_MIN = 4'(PRE_MIN_NIBBLES);
  localparam logic [LEN_W-1:0] c_MIN_LEN = LEN_W'(MIN_BYTES);
  localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_BYTES);

  logic [1:0]       state_q, state_d;
  logic [3:0]       pre_cnt_q, pre_cnt_d;
  logic             phase_q, phase_d;
  logic [3:0]       low_q, low_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             first_q, first_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic             out_err_q, out_err_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic [LEN_W-1:0] good_cnt_q, good_cnt_d;
  logic [LEN_W-1:0] err_cnt_q, err_cnt_d;

  logic             w_dv;
  logic [3:0]       w_rxd;
  logic             w_sfd;
  logic             w_keep;
  logic             w_err;
  logic             w_fcs_bad;
  logic [LEN_W-1:0] w_len_inc;

  assign w_dv      = rx_bus.eth_rx_dv;
  assign w_rxd     = rx_bus.eth_rxd;
  assign w_sfd     = (state_q == c_ST_PRE) && w_dv && (w_rxd == c_NIB_SFD) &&
                     (pre_cnt_q >= c_PRE_MIN);
  assign w_keep    = (len_q < c_MAX_LEN);
  assign w_len_inc = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + 1'b1;
  // phase_q=1 at dv fall means a low nibble is waiting for its partner
  assign w_err     = (len_q < c_MIN_LEN) || (len_q > c_MAX_LEN) || phase_q || w_fcs_bad;

`ifdef MII_RX_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
      else                c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (w_sfd)
      crc_d = 32'hFFFFFFFF;
    else if ((state_q == c_ST_DATA) && w_dv && phase_q)
      crc_d = crc32_byte(crc_q, {w_rxd, low_q});
  end

  always_ff @(posedge eth_rx_clk or posedge rst) begin
    if (rst) crc_q <= 32'hFFFFFFFF;
    else     crc_q <= crc_d;
  end

  // the register holds the reflected form of the magic residue
  assign w_fcs_bad = (bit_rev32(crc_q) != 32'hC704DD7B);
`else
  assign w_fcs_bad = 1'b0;
`endif

  always_ff @(posedge eth_rx_clk or posedge rst) begin
    if (rst) state_q <= c_ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_dv) state_d = (w_rxd == c_NIB_PRE) ? c_ST_PRE : c_ST_DROP;
      end
      c_ST_PRE: begin
        if (!w_dv)                  state_d = c_ST_IDLE;
        else if (w_sfd)             state_d = c_ST_DATA;
        else if (w_rxd != c_NIB_PRE) state_d = c_ST_DROP;
      end
      c_ST_DATA: begin
        if (!w_dv) state_d = c_ST_IDLE;
      end
      c_ST_DROP: begin
        if (!w_dv) state_d = c_ST_IDLE;
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  always_comb begin
    pre_cnt_d   = pre_cnt_q;
    phase_d     = phase_q;
    low_d       = low_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    first_d     = first_q;
    len_d       = len_q;
    out_data_d  = 8'h00;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_eof_d   = 1'b0;
    out_err_d   = 1'b0;
    frame_len_d = '0;
    good_cnt_d  = good_cnt_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_dv && (w_rxd == c_NIB_PRE)) pre_cnt_d = 4'd1;
      end
      c_ST_PRE: begin
        if (w_dv && (w_rxd == c_NIB_PRE)) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 1'b1;
        end else if (w_sfd) begin
          phase_d    = 1'b0;
          len_d      = '0;
          hold_vld_d = 1'b0;
          first_d    = 1'b1;
        end
      end
      c_ST_DATA: begin
        if (!w_dv) begin
          if (hold_vld_q) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_q;
            out_sof_d   = first_q;
            out_eof_d   = 1'b1;
            out_err_d   = w_err;
            frame_len_d = len_q;
            if (w_err) err_cnt_d  = err_cnt_q + 1'b1;
            else       good_cnt_d = good_cnt_q + 1'b1;
          end else begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          hold_vld_d = 1'b0;
          phase_d    = 1'b0;
          first_d    = 1'b0;
        end else if (!phase_q) begin
          low_d   = w_rxd;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          len_d   = w_len_inc;
          // oversize bytes still count toward len but never reach hold
          if (w_keep) begin
            if (hold_vld_q) begin
              out_valid_d = 1'b1;
              out_data_d  = hold_q;
              out_sof_d   = first_q;
              first_d     = 1'b0;
            end
            hold_d     = {w_rxd, low_q};
            hold_vld_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge eth_rx_clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q   <= 4'd0;
      phase_q     <= 1'b0;
      low_q       <= 4'd0;
      hold_q      <= 8'h00;
      hold_vld_q  <= 1'b0;
      first_q     <= 1'b0;
      len_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      frame_len_q <= '0;
      good_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      phase_q     <= phase_d;
      low_q       <= low_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      first_q     <= first_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_err_q   <= out_err_d;
      frame_len_q <= frame_len_d;
      good_cnt_q  <= good_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rx_bus.out_data  = out_data_q;
  assign rx_bus.out_valid = out_valid_q;
  assign rx_bus.out_sof   = out_sof_q;
  assign rx_bus.out_eof   = out_eof_q;
  assign rx_bus.out_err   = out_err_q;
  assign rx_bus.frame_len = frame_len_q;
  assign rx_bus.good_cnt  = good_cnt_q;
  assign rx_bus.err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: doc/mii_rx_framer.md
Name: mii_rx_framer

Overview:
- Receive-side MII framer between the PHY pins (eth_rx_dv/eth_rxd) and the LED display and other frame consumers.
- Strips preamble and SFD, assembles nibbles into bytes (low nibble first), and marks frame start and end.
- Flags length, alignment and (optionally) FCS errors, and keeps good and bad frame counters.
- Runs entirely in the eth_rx_clk domain (25 MHz).

Parameters:
- PRE_MIN_NIBBLES, 1: minimum count of 0x5 preamble nibbles before SFD is accepted (1..15).
- MIN_BYTES, 64: frames shorter than this, FCS included, are errored.
- MAX_BYTES, 1518: frames longer than this are errored; bytes beyond it are not emitted.
- LEN_W, 16: width of frame_len and of both counters.

Ports:
- eth_rx_clk  in  1  MII receive clock; the only clock.
- rst  in  1  asynchronous active-high reset.
- eth_rx_dv  in  1  MII receive data valid.
- eth_rxd  in  4  MII receive nibble.
- out_data  out  8  assembled byte.
- out_valid  out  1  one-cycle strobe; out_data/sof/eof valid.
- out_sof  out  1  first byte after SFD (qualified by out_valid).
- out_eof  out  1  last byte of frame (qualified by out_valid).
- out_err  out  1  frame error, valid only with out_eof.
- frame_len  out  LEN_W  byte count of the finished frame, valid with out_eof.
- good_cnt  out  LEN_W  count of frames ending with out_err=0; wraps.
- err_cnt  out  LEN_W  count of errored or empty frames; wraps.

Behaviour:
- Clock and reset: one clock, eth_rx_clk. Reset is asynchronous and active-high on rst. While rst=1, all outputs are 0, FSM is in IDLE, hold and assembly registers are cleared.
- Reset mid-frame: drops the frame silently. No eof, no counter change.
- All outputs are registered. eth_rx_dv/eth_rxd are sampled on the rising edge of eth_rx_clk.
- State IDLE:
  - dv=1 and rxd=0x5: go to PREAMBLE, pre_cnt=1.
  - dv=1 and rxd≠0x5: go to DROP.
- State PREAMBLE:
  - dv=0: go to IDLE, no output.
  - rxd=0x5: pre_cnt++ (saturates at 15).
  - rxd=0xD and pre_cnt≥PRE_MIN_NIBBLES: go to DATA, phase=LOW, len=0.
  - Any other nibble: go to DROP.
- State DATA:
  - phase LOW: capture nibble into bits [3:0].
  - phase HIGH: form the byte {rxd, low}, then len++ (saturates at 2^LEN_W−1).
  - One-byte hold stage: a completed byte enters hold. If hold was occupied, the held byte is emitted (out_valid=1) in the next cycle; out_sof=1 for the first emitted byte of the frame.
  - Bytes with index ≥ MAX_BYTES are counted but neither held nor emitted.
  - dv=0 sampled: go to IDLE. If hold is occupied, emit the held byte next cycle with out_eof=1 and frame_len=len.
- Latency:
  - Byte N is emitted 1 cycle after the high nibble of byte N+1 is sampled.
  - The last byte is emitted 1 cycle after dv=0 is sampled.
- State DROP: ignore input until dv=0, then go to IDLE. No output, no counter change.
- out_err=1 at eof if any of:
  - len < MIN_BYTES;
  - len > MAX_BYTES;
  - dv fell in phase HIGH (odd nibble count; the partial byte is discarded).
- Counters at eof:
  - out_err=0: good_cnt++.
  - out_err=1: err_cnt++.
- Empty frame (dv falls with zero complete bytes after SFD): no out_valid, err_cnt++.
- Single-byte frame: one strobe with out_sof=out_eof=1, out_err=1 (below MIN_BYTES).
- Back-to-back frames: minimum 1 cycle of dv=0. The eof strobe of frame k and IDLE detection of frame k+1 may overlap without loss.
- Counters wrap from 2^LEN_W−1 to 0.

Optional Feature:
- Macro: MII_RX_FCS_CHECK_EN.
- Defined:
  - A CRC-32 (IEEE 802.3, reflected, init 0xFFFFFFFF) is updated per completed byte, FCS bytes included.
  - At eof, a residue ≠ 0xC704DD7B also sets out_err.
  - The CRC resets on SFD.
- Undefined: no CRC logic; out_err depends only on the length and alignment rules.

Test Plan:
1. 15×0x5, 0xD, then 64 bytes 0x00..0x3F, then dv=0 → 64 strobes with out_data matching; sof on 0x00, eof on 0x3F, frame_len=64, out_err=0, good_cnt=1.
2. Same frame with an odd trailing nibble 0xA before dv=0 → 64 strobes, eof with out_err=1, err_cnt=1, good_cnt unchanged.
3. Preamble then SFD then dv=0 immediately → no out_valid, err_cnt=1. Separately, preamble 0x5,0x5,0x7 → DROP, no output, no counter change.
4. 1600-byte frame → exactly 1518 strobes, eof on the 1518th, frame_len=1600, out_err=1.
5. rst pulsed after byte 20 of a 64-byte frame → outputs immediately 0, no eof. The next valid frame is received normally, good_cnt=1.
6. MII_RX_FCS_CHECK_EN defined: 60-byte payload plus correct FCS → out_err=0. Same frame with one payload bit flipped → out_err=1, err_cnt++.
